// File: rtl/rect_fill.sv
// Rectangle fill engine: plots an axis-aligned rectangle, clipped to the
// screen, into the VGA adapter plot port at one pixel per clock.
// Traversal is column-major (y inner). The colour is solid, a column stripe
// or a row stripe, selected by mode.
module rect_fill #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] colour,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);

    localparam logic [XW:0] SW = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] SH = (YW+1)'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t        state;
    logic [YW-1:0] y_org;
    logic [XW:0]   x_end_q;
    logic [YW:0]   y_end_q;
    logic [CW-1:0] col_q;
    logic [1:0]    mode_q;

    logic [XW:0]   x_sum, x_end;
    logic [YW:0]   y_sum, y_end;
    logic          empty;
    logic          wrap, last;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;

    // Pixel colour for a given mode and position; the stripes add the
    // low coordinate bits to the base colour, wrapping mod 2^CW.
    function automatic logic [CW-1:0] pix_col(input logic [1:0] m,
                                              input logic [CW-1:0] c,
                                              input logic [XW-1:0] px,
                                              input logic [YW-1:0] py);
        case (m)
            2'd1:    pix_col = c + px[CW-1:0];
            2'd2:    pix_col = c + py[CW-1:0];
            default: pix_col = c;
        endcase
    endfunction

    // Clip the requested extent to the screen. The sums are one bit wider so
    // that they cannot overflow.
    always_comb begin
        x_sum = {1'b0, x0} + {1'b0, w};
        y_sum = {1'b0, y0} + {1'b0, h};
        x_end = (x_sum > SW) ? SW : x_sum;
        y_end = (y_sum > SH) ? SH : y_sum;
        empty = ({1'b0, x0} >= SW) || ({1'b0, y0} >= SH) || (w == '0) || (h == '0);
    end

    // Next pixel position: y steps inside a column and wraps to the top row,
    // then x steps.
    always_comb begin
        wrap = (({1'b0, vga_y} + (YW+1)'(1)) == y_end_q);
        last = wrap && (({1'b0, vga_x} + (XW+1)'(1)) == x_end_q);
        nx   = wrap ? vga_x + XW'(1) : vga_x;
        ny   = wrap ? y_org : vga_y + YW'(1);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            y_org      <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            col_q      <= '0;
            mode_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        y_org   <= y0;
                        x_end_q <= x_end;
                        y_end_q <= y_end;
                        col_q   <= colour;
                        mode_q  <= mode;
                        if (empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= FILL;
                            busy       <= 1'b1;
                            vga_plot   <= 1'b1;
                            vga_x      <= x0;
                            vga_y      <= y0;
                            vga_colour <= pix_col(mode, colour, x0, y0);
                        end
                    end
                end
                FILL: begin
                    if (last) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        vga_plot <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        vga_x      <= nx;
                        vga_y      <= ny;
                        vga_colour <= pix_col(mode_q, col_q, nx, ny);
                    end
                end
                DONE: begin
                    // Hold done until the controller releases start.
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    vga_plot <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill.sv
// Bench for rect_fill: a table of directed rectangles with hand-computed
// counts and corner pixels, a per-pixel order and colour model, and hand
// sequences covering long start hold, restart, and reset during a fill.
module tb_rect_fill;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] x0, w;
    logic [6:0] y0, h;
    logic [2:0] colour;
    logic [1:0] mode;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int n_chk = 0;
    int n_fail = 0;

    rect_fill dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h), .colour(colour), .mode(mode),
        .busy(busy), .done(done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0, y0, w, h, col, md;
        int hold;                // cycles to keep start high after done
        int cnt;                 // expected plot count
        int fx, fy, fc;          // expected first pixel
        int lx, ly, lc;          // expected last pixel
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one rectangle with start held high, then watch every cycle.
    task automatic run_vec(input vec_t v, input string tag);
        int cnt, ex, ey, xe, ye, ec, cyc, done_cyc;
        int fx, fy, fc, lx, ly, lc;
        bit order_err, gap_err, range_err, hold_err;
        cnt = 0; cyc = 0; done_cyc = -1;
        fx = -1; fy = -1; fc = -1; lx = -1; ly = -1; lc = -1;
        order_err = 0; gap_err = 0; range_err = 0; hold_err = 0;
        ex = v.x0; ey = v.y0;
        xe = (v.x0 + v.w > 160) ? 160 : v.x0 + v.w;
        ye = (v.y0 + v.h > 120) ? 120 : v.y0 + v.h;
        @(negedge clk);
        x0 = 8'(v.x0); y0 = 7'(v.y0); w = 8'(v.w); h = 7'(v.h);
        colour = 3'(v.col); mode = 2'(v.md); start = 1'b1;
        while (done_cyc < 0 && cyc < 25000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) begin
                // Inputs other than start must be ignored mid-fill.
                x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom);
                h = 7'($urandom); colour = 3'($urandom); mode = 2'($urandom);
            end
            if (vga_plot) begin
                cnt++;
                if (cyc != cnt) gap_err = 1;
                if (vga_x >= 160 || vga_y >= 120) range_err = 1;
                ec = (v.md == 1) ? (v.col + ex) % 8 :
                     (v.md == 2) ? (v.col + ey) % 8 : v.col;
                if (int'(vga_x) != ex || int'(vga_y) != ey || int'(vga_colour) != ec)
                    order_err = 1;
                if (cnt == 1) begin fx = vga_x; fy = vga_y; fc = vga_colour; end
                lx = vga_x; ly = vga_y; lc = vga_colour;
                ey++;
                if (ey == ye) begin ey = v.y0; ex++; end
            end
            if (done) done_cyc = cyc;
        end
        chk({tag, " plot count"}, cnt, v.cnt);
        chk({tag, " done cycle"}, done_cyc, v.cnt + 1);
        chk({tag, " no gaps"}, int'(gap_err), 0);
        chk({tag, " in range"}, int'(range_err), 0);
        chk({tag, " order/colour"}, int'(order_err), 0);
        if (v.cnt > 0) begin
            chk({tag, " first x"}, fx, v.fx);
            chk({tag, " first y"}, fy, v.fy);
            chk({tag, " first colour"}, fc, v.fc);
            chk({tag, " last x"}, lx, v.lx);
            chk({tag, " last y"}, ly, v.ly);
            chk({tag, " last colour"}, lc, v.lc);
        end
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            if (!done || vga_plot || busy) hold_err = 1;
        end
        chk({tag, " done held, no replot"}, int'(hold_err), 0);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{0,   0,   160, 120, 0, 1, 10800, 19200, 0, 0, 0, 159, 119, 7};
        vecs[1] = '{10,  20,  4,   3,   6, 0, 3, 12, 10, 20, 6, 13, 22, 6};
        vecs[2] = '{158, 118, 5,   5,   1, 2, 3, 4, 158, 118, 7, 159, 119, 0};
        vecs[3] = '{20,  20,  0,   5,   2, 0, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{200, 20,  5,   5,   2, 0, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{5,   5,   2,   2,   3, 3, 3, 4, 5, 5, 3, 6, 6, 3};
        vecs[6] = '{30,  40,  7,   0,   1, 1, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[7] = '{10,  120, 4,   4,   1, 2, 3, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1; start = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; colour = '0; mode = '0;
        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset plot", int'(vga_plot), 0);
        chk("reset xycol", int'({vga_x, vga_y, vga_colour}), 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 1; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            @(negedge clk); start = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("v%0d done drop", i), int'(done), 0);
        end

        // Full screen with start held ~30000 cycles, then a one-cycle low pulse.
        run_vec(vecs[0], "full");
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        chk("restart plot", int'(vga_plot), 1);
        chk("restart busy", int'(busy), 1);
        chk("restart done", int'(done), 0);
        // Let 50 plots occur, then reset asynchronously mid-fill.
        for (int i = 1; i < 50; i++) begin @(posedge clk); #1; end
        chk("restart still plotting", int'(vga_plot), 1);
        start = 1'b0;
        rst = 1'b1; #1;
        chk("async rst plot", int'(vga_plot), 0);
        chk("async rst busy", int'(busy), 0);
        @(negedge clk); rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (vga_plot) cnt++;
        end
        chk("no plots after reset", cnt, 0);
        chk("idle after reset", int'({busy, done}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
